// File: rtl/led_cube_scanner_pkg.sv
// Shared constants, header pin map and FSM state type for the LED cube scanner.
package led_cube_scanner_pkg;

    localparam int           CUBE_N    = 8;
    localparam int           COORD_W   = 4;
    localparam int           COLS      = 64;
    localparam int           LAYER_W   = 3;
    localparam logic [3:0]   COLOR_OFF = 4'd15;

    // Header pin map: each 36-pin header carries 32 columns and 4 layer selects.
    localparam int HDR_W          = 36;
    localparam int COLS_PER_HDR   = 32;
    localparam int JP1_COL_BASE   = 0;
    localparam int JP2_COL_BASE   = 32;
    localparam int LAYER_PIN_OFF  = 32;
    localparam int LAYERS_PER_HDR = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/led_cube_scanner_scan_timer.sv
// Dwell/layer timebase for the layer multiplexer.
module cube_scan_timer
    import led_cube_scanner_pkg::*;
#(
    parameter int DWELL = 6250,
    parameter int BLANK = 50
) (
    input  logic               clk,
    input  logic               resetn,
    output logic [LAYER_W-1:0] o_layer,
    output logic               o_blank,
    output logic               o_frame_wrap
);

    localparam int DW_W = $clog2(DWELL);

    logic [DW_W-1:0]    r_dwell;
    logic [LAYER_W-1:0] r_layer;
    logic               w_dwell_wrap;

    assign w_dwell_wrap = (r_dwell == DW_W'(DWELL - 1));
    assign o_layer      = r_layer;
    assign o_blank      = (r_dwell < DW_W'(BLANK));
    // Last cycle of the last layer: the edge leaving it starts a new frame.
    assign o_frame_wrap = w_dwell_wrap && (r_layer == LAYER_W'(CUBE_N - 1));

    // Dwell counter runs 0..DWELL-1; layer steps on each dwell wrap and rolls 7->0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dwell <= '0;
            r_layer <= '0;
        end else if (w_dwell_wrap) begin
            r_dwell <= '0;
            r_layer <= r_layer + LAYER_W'(1);
        end else begin
            r_dwell <= r_dwell + DW_W'(1);
        end
    end

endmodule

// File: rtl/led_cube_scanner.sv
// Double-buffered 8x8x8 voxel store with layer-multiplexed header outputs.
module led_cube_scanner
    import led_cube_scanner_pkg::*;
#(
    parameter int DWELL = 6250,
    parameter int BLANK = 50
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wr_en,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_z,
    input  logic [3:0]         wr_color,
    input  logic               clr,
    input  logic               swap_req,
    output logic               busy,
    output logic               wr_drop,
    output logic               swap_done,
    output logic [HDR_W-1:0]   jp1,
    output logic [HDR_W-1:0]   jp2
);

    state_t                               r_state, w_state_nxt;
    logic [LAYER_W-1:0]                   r_row;
    logic [1:0][CUBE_N-1:0][COLS-1:0]     r_buf;
    logic                                 r_fsel, r_pend, r_drop, r_done;
    logic [HDR_W-1:0]                     r_jp1, r_jp2, w_jp1_nxt, w_jp2_nxt;
    logic [LAYER_W-1:0]                   w_layer;
    logic                                 w_blank, w_frame_wrap;
    logic                                 w_busy, w_wr_ok, w_back, w_swap;
    logic [5:0]                           w_col;
    logic [COLS-1:0]                      w_row;
    logic [CUBE_N-1:0]                    w_sel;

    cube_scan_timer #(.DWELL(DWELL), .BLANK(BLANK)) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .o_layer      (w_layer),
        .o_blank      (w_blank),
        .o_frame_wrap (w_frame_wrap)
    );

    assign w_busy  = (r_state == ST_CLEAR);
    assign w_back  = ~r_fsel;
    assign w_col   = {wr_z[2:0], wr_x[2:0]};
    assign w_wr_ok = wr_en && !w_busy
                     && (wr_x < COORD_W'(CUBE_N))
                     && (wr_y < COORD_W'(CUBE_N))
                     && (wr_z < COORD_W'(CUBE_N));
    // Swap only on a frame boundary and never while a clear sweep owns the back buffer.
    assign w_swap  = w_frame_wrap && r_pend && !w_busy;

    assign busy      = w_busy;
    assign wr_drop   = r_drop;
    assign swap_done = r_done;
    assign jp1       = r_jp1;
    assign jp2       = r_jp2;

    // Clear FSM state and row pointer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_busy ? r_row + LAYER_W'(1) : '0;
        end
    end

    // Clear FSM next state: one back-buffer row per cycle, eight rows total.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (clr) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_row == LAYER_W'(CUBE_N - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame store: clear sweep or accepted write, always into the back buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_buf <= '0;
        end else if (w_busy) begin
            r_buf[w_back][r_row] <= '0;
        end else if (w_wr_ok) begin
            r_buf[w_back][wr_y[2:0]][w_col] <= (wr_color != COLOR_OFF);
        end
    end

    // Front select, pending swap and status pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fsel <= 1'b0;
            r_pend <= 1'b0;
            r_drop <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_drop <= wr_en && !w_wr_ok;
            r_done <= w_swap;
            if (w_swap) begin
                r_fsel <= ~r_fsel;
                r_pend <= swap_req;
            end else begin
                r_pend <= r_pend | swap_req;
            end
        end
    end

    // Map the current front layer onto the two headers.
    always_comb begin
        w_row     = r_buf[r_fsel][w_layer];
        w_sel     = CUBE_N'(1) << w_layer;
        w_jp1_nxt = '0;
        w_jp2_nxt = '0;
        w_jp1_nxt[COLS_PER_HDR-1:0]                  = w_row[JP1_COL_BASE +: COLS_PER_HDR];
        w_jp2_nxt[COLS_PER_HDR-1:0]                  = w_row[JP2_COL_BASE +: COLS_PER_HDR];
        w_jp1_nxt[LAYER_PIN_OFF +: LAYERS_PER_HDR]   = w_sel[0 +: LAYERS_PER_HDR];
        w_jp2_nxt[LAYER_PIN_OFF +: LAYERS_PER_HDR]   = w_sel[LAYERS_PER_HDR +: LAYERS_PER_HDR];
    end

    // Registered header drive, forced dark during the blanking window.
    always_ff @(posedge clk) begin
        if (!resetn || w_blank) begin
            r_jp1 <= '0;
            r_jp2 <= '0;
        end else begin
            r_jp1 <= w_jp1_nxt;
            r_jp2 <= w_jp2_nxt;
        end
    end

endmodule

// File: tb/tb_led_cube_scanner.sv
// Randomized and directed bench for led_cube_scanner against a frame-level model.
module tb_led_cube_scanner;

    localparam int DWELL = 64;
    localparam int BLANK = 4;
    localparam int FRAME = 8 * DWELL;

    logic        clk = 1'b0;
    logic        resetn, wr_en, clr, swap_req;
    logic [3:0]  wr_x, wr_y, wr_z, wr_color;
    logic        busy, wr_drop, swap_done;
    logic [35:0] jp1, jp2;
    logic [74:0] obs;

    int checks = 0;
    int errors = 0;

    led_cube_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_z(wr_z), .wr_color(wr_color), .clr(clr), .swap_req(swap_req),
        .busy(busy), .wr_drop(wr_drop), .swap_done(swap_done), .jp1(jp1), .jp2(jp2)
    );

    always #5 clk = ~clk;
    assign obs = {busy, wr_drop, swap_done, jp1, jp2};

    // Reference model: time since reset decides layer/dwell; buffers are plain bit arrays.
    bit          mb [2][8][64];
    bit          mf, mp;
    int          mcl, mt;
    logic [74:0] mexp;

    always @(posedge clk) begin : model
        logic [35:0] e1, e2;
        bit busy0, ok, drop, done;
        int ly, ph, bk;
        if (!resetn) begin
            foreach (mb[i, j, k]) mb[i][j][k] = 1'b0;
            mf = 0; mp = 0; mcl = 0; mt = 0; mexp = '0;
        end else begin
            ph = mt % DWELL;
            ly = (mt / DWELL) % 8;
            e1 = '0; e2 = '0;
            if (ph >= BLANK) begin
                for (int c = 0; c < 64; c++)
                    if (mb[mf][ly][c]) begin
                        if (c < 32) e1[c] = 1'b1; else e2[c-32] = 1'b1;
                    end
                if (ly < 4) e1[32+ly] = 1'b1; else e2[32+ly-4] = 1'b1;
            end
            busy0 = (mcl > 0);
            bk    = mf ? 0 : 1;
            ok    = wr_en && (wr_x < 8) && (wr_y < 8) && (wr_z < 8) && !busy0;
            drop  = wr_en && !ok;
            if (ok) mb[bk][int'(wr_y)][int'(wr_z) * 8 + int'(wr_x)] = (wr_color != 4'd15);
            if (busy0) begin
                for (int c = 0; c < 64; c++) mb[bk][8-mcl][c] = 1'b0;
                mcl--;
            end else if (clr) begin
                mcl = 8;
            end
            done = 0;
            if ((mt % FRAME) == FRAME - 1 && mp && !busy0) begin
                mf = !mf; mp = swap_req; done = 1;
            end else begin
                mp = mp | swap_req;
            end
            mt++;
            mexp = {(mcl > 0), drop, done, e1, e2};
        end
    end

    task automatic drv(input logic en, input int x, input int y, input int z,
                       input int col, input logic c, input logic s);
        wr_en = en; wr_x = 4'(x); wr_y = 4'(y); wr_z = 4'(z);
        wr_color = 4'(col); clr = c; swap_req = s;
    endtask

    // Idle until the model's timebase sits at a frame start.
    task automatic align();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < FRAME && (mt % FRAME) != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drv($urandom % 2, $urandom % 8, $urandom % 8, $urandom % 8, 0, $urandom % 2, $urandom % 2);
            @(negedge clk);
            checks++;
            if (obs !== 75'd0) begin
                errors++; $display("FAIL reset cyc %0d got %h exp 0", c, obs);
            end
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
    endtask

    task automatic test_basic_write();
        align();
        for (int c = 0; c <= 1000; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL basic_model cyc %0d got %h exp %h", c, obs, mexp); end
            if (c == 480) begin
                checks++;
                if ({jp1, jp2} !== {36'h0, 36'h800000000}) begin
                    errors++; $display("FAIL basic_preswap got %h exp %h", {jp1, jp2}, {36'h0, 36'h800000000});
                end
            end
            if (c == 449 || c == 513 || c == 961) begin
                checks++;
                if ({jp1, jp2} !== 72'd0) begin errors++; $display("FAIL basic_blank cyc %0d got %h exp 0", c, {jp1, jp2}); end
            end
            if (c == 512) begin
                checks++;
                if (swap_done !== 1'b1) begin errors++; $display("FAIL basic_swap_done got %b exp 1", swap_done); end
            end
            if (c == 992) begin
                checks++;
                if ({jp1, jp2} !== {36'h000040000, 36'h800000000}) begin
                    errors++; $display("FAIL basic_layer7 got %h exp %h", {jp1, jp2}, {36'h000040000, 36'h800000000});
                end
            end
            drv(c == 0, 2, 7, 2, 0, 0, c == 100);
            @(negedge clk);
        end
    endtask

    task automatic test_drop_and_clear_voxel();
        align();
        for (int c = 0; c <= 560; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL drop_model cyc %0d got %h exp %h", c, obs, mexp); end
            if (c == 1 || c == 2) begin
                checks++;
                if (wr_drop !== (c == 1)) begin errors++; $display("FAIL drop_pulse cyc %0d got %b exp %b", c, wr_drop, c == 1); end
            end
            if (c == 552) begin
                checks++;
                if ({jp1, jp2} !== {36'h100000008, 36'h0}) begin
                    errors++; $display("FAIL drop_layer0 got %h exp %h", {jp1, jp2}, {36'h100000008, 36'h0});
                end
            end
            case (c)
                0:       drv(1, 8, 0, 0, 0, 0, 0);
                3:       drv(1, 1, 0, 0, 0, 0, 0);
                4:       drv(1, 3, 0, 0, 0, 0, 0);
                6:       drv(1, 1, 0, 0, 15, 0, 0);
                20:      drv(0, 0, 0, 0, 0, 0, 1);
                default: drv(0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_clr();
        int nbusy = 0;
        logic [31:0] nz = '0;
        align();
        for (int c = 0; c <= 1025; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL clr_model cyc %0d got %h exp %h", c, obs, mexp); end
            if (busy === 1'b1) nbusy++;
            if (c > 513) nz = nz | jp1[31:0] | jp2[31:0];
            if (c == 74) begin
                checks++;
                if (wr_drop !== 1'b1) begin errors++; $display("FAIL clr_busy_drop got %b exp 1", wr_drop); end
            end
            if (c < 64)       drv(1, $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 15, 0, 0);
            else if (c == 70) drv(0, 0, 0, 0, 0, 1, 0);
            else if (c == 73) drv(1, 0, 0, 0, 0, 0, 0);
            else              drv(0, 0, 0, 0, 0, 0, c == 100);
            @(negedge clk);
        end
        checks++;
        if (nbusy != 8) begin errors++; $display("FAIL clr_busy_len got %0d exp 8", nbusy); end
        checks++;
        if (nz !== 32'd0) begin errors++; $display("FAIL clr_cleared got %h exp 0", nz); end
    endtask

    task automatic test_back_to_back_swap();
        int ndone = 0;
        align();
        for (int c = 0; c <= 1100; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL dswap_model cyc %0d got %h exp %h", c, obs, mexp); end
            if (swap_done === 1'b1) ndone++;
            if (c == 512 || c == 1024) begin
                checks++;
                if (swap_done !== 1'b1) begin errors++; $display("FAIL dswap_done cyc %0d got %b exp 1", c, swap_done); end
            end
            drv(0, 0, 0, 0, 0, 0, c == 50 || c == 60 || c == 511);
            @(negedge clk);
        end
        checks++;
        if (ndone != 2) begin errors++; $display("FAIL dswap_count got %0d exp 2", ndone); end
    endtask

    task automatic test_swap_deferred();
        int ndone = 0;
        align();
        for (int c = 0; c <= 1030; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL defer_model cyc %0d got %h exp %h", c, obs, mexp); end
            if (swap_done === 1'b1) ndone++;
            if (c == 512 || c == 1024) begin
                checks++;
                if (swap_done !== (c == 1024)) begin
                    errors++; $display("FAIL defer_done cyc %0d got %b exp %b", c, swap_done, c == 1024);
                end
            end
            drv(0, 0, 0, 0, 0, c == 505, c == 10);
            @(negedge clk);
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL defer_count got %0d exp 1", ndone); end
    endtask

    task automatic test_reset_mid_clear();
        int ndone = 0;
        logic [31:0] nz = '0;
        align();
        for (int c = 0; c <= 1800; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL rstclr_model cyc %0d got %h exp %h", c, obs, mexp); end
            if (c == 15) begin
                checks++;
                if (obs !== 75'd0) begin errors++; $display("FAIL rstclr_outputs got %h exp 0", obs); end
            end
            if (c > 15 && c < 700 && swap_done === 1'b1) ndone++;
            if (c > 15) nz = nz | jp1[31:0] | jp2[31:0];
            resetn = !(c == 13 || c == 14);
            if (c < 4) drv(1, c, 2, 1, 0, 0, 0);
            else       drv(0, 0, 0, 0, 0, c == 10, c == 5 || c == 700);
            @(negedge clk);
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL rstclr_no_swap got %0d exp 0", ndone); end
        checks++;
        if (nz !== 32'd0) begin errors++; $display("FAIL rstclr_cleared got %h exp 0", nz); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (obs !== mexp) begin errors++; $display("FAIL random_model cyc %0d got %h exp %h", c, obs, mexp); end
            resetn = ($urandom % 1500) != 0;
            drv($urandom % 2, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom % 16, ($urandom % 64) == 0, ($urandom % 50) == 0);
            @(negedge clk);
        end
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_write();
        test_drop_and_clear_voxel();
        test_clr();
        test_back_to_back_swap();
        test_swap_deferred();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_cube_scanner.md
Name: led_cube_scanner

Overview:
- Receiving end of the voxel-write interface that animation blocks (countdown, menus, games) drive with enable/X/Y/Z/color.
- Stores voxels for an 8x8x8 single-colour LED cube in a double-buffered frame store.
- Continuously multiplexes one layer at a time onto the two 36-pin GPIO headers, with blanking to suppress ghosting.
- Producers write into the back buffer; a swap request makes the new frame visible on a frame boundary.

Parameters:
- DWELL, 6250: clock cycles each layer is scanned (50 MHz gives 1 kHz full-cube refresh); legal range 16..2^20-1.
- BLANK, 50: cycles at the start of each dwell where all column and layer outputs are 0; must be less than DWELL.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- wr_en  in  1  voxel write strobe, one write per cycle
- wr_x  in  4  X coordinate, valid 0..7
- wr_y  in  4  Y coordinate = layer, valid 0..7
- wr_z  in  4  Z coordinate, valid 0..7
- wr_color  in  4  15 = clear voxel; any other value = set voxel
- clr  in  1  pulse: clear entire back buffer
- swap_req  in  1  pulse: request front/back exchange
- busy  out  1  high while a clear sweep runs
- wr_drop  out  1  1-cycle pulse when a write is rejected
- swap_done  out  1  1-cycle pulse in the cycle the swap takes effect
- jp1  out  36  header 1
- jp2  out  36  header 2

Behaviour:
- Reset (resetn=0 at clk edge):
  - Both buffers are cleared to 0 and the front buffer select is 0.
  - Layer counter is 0, dwell counter is 0, and no swap is pending.
  - busy, wr_drop and swap_done are 0; jp1 and jp2 are all 0.
  - Reset mid-clear or mid-swap aborts the operation; reset always wins.
- Writes:
  - Only the back buffer is written. Voxel index is (y, z*8+x).
  - A write is rejected if any coordinate is above 7, or if busy=1.
  - A rejected write leaves the buffer unchanged and pulses wr_drop one cycle later, registered.
  - An accepted write is visible in the back buffer on the next cycle.
- Clear, as a state machine IDLE -> CLEAR -> IDLE:
  - clr in IDLE enters CLEAR on the next edge and asserts busy.
  - CLEAR zeroes one Y row (64 bits) of the back buffer per cycle, y = 0..7, so busy is high for exactly 8 cycles.
  - clr while busy is ignored.
- Scan:
  - The dwell counter runs 0..DWELL-1. On wrap the layer advances 0..7, and 7 wraps to 0.
  - While dwell < BLANK, all outputs are 0.
  - Otherwise, column c = z*8+x is driven from front[layer][c]. Columns 0..31 map to jp1[31:0] and columns 32..63 to jp2[31:0].
  - Layer select is one-hot active-high: layers 0..3 on jp1[32+l], layers 4..7 on jp2[32+l-4].
  - Outputs are registered, with 1-cycle latency from the counters.
- Swap:
  - swap_req sets a pending flag; a further swap_req while pending is absorbed.
  - The swap executes on the edge where layer 7 / dwell DWELL-1 wraps to layer 0. At that edge the front select toggles, pending clears and swap_done pulses.
  - The new back buffer is not copied or cleared; producers redraw it or issue clr.
  - A write accepted in the swap-execute cycle lands in the pre-swap back buffer, so it becomes visible.
  - swap_req arriving on the same edge as execution is taken as a new pending request.
  - swap_req while busy stays pending; a swap never executes while busy=1 and waits for the next frame boundary instead.
- Simultaneous clr and wr_en in IDLE: the write is accepted first, then CLEAR starts and erases it.

Decomposition:
- Shared package holds:
  - constants CUBE_N=8, COORD_W=4, COLS=64, COLOR_OFF=4'd15;
  - the header pin map (column base offsets and layer pin offsets);
  - the state enum {ST_IDLE, ST_CLEAR}.
- One sub-module, cube_scan_timer, holds the dwell and layer counters and generates blank, layer and frame_wrap strobes.
- Buffers, the write path, the clear FSM and output mapping stay in led_cube_scanner.

Test Plan:
- Reset, then write (x=2, y=7, z=2, color=0) with DWELL=64, BLANK=4:
  - the write appears only after swap_req at the next frame wrap;
  - during the layer-7 window, jp1[18]=1 and jp2[35]=1; all other bits are 0;
  - during the blank cycles, all bits are 0.
- Write (x=8, y=0, z=0) -> wr_drop pulses once and the buffer is unchanged after swap; write (x=1, y=0, z=0, color=15) after a set -> the voxel clears.
- Fill the back buffer, pulse clr -> busy is high for exactly 8 cycles; a write during busy is dropped; after swap, all columns read 0 in every layer.
- Double swap:
  - swap_req twice mid-frame -> exactly one swap_done, at the layer 7->0 wrap, and the front select toggles once;
  - swap_req on the wrap edge -> a second swap_done one frame later.
- Swap pending while busy at the wrap -> the swap is deferred one full frame (8*DWELL cycles).
- Assert resetn=0 mid-CLEAR with a swap pending -> busy=0, outputs 0, no swap_done afterward, and the buffers are cleared.
